bpu_gshare: RTL and testbench

Parametrised gshare branch prediction unit for the fetch stage, successor of the fixed-size `bpu`. It predicts direction and target for the PC presented by fetch and updates its tables from branch resolutions coming back from execute. It combines:
- a PHT of saturating counters indexed by PC XOR global history;
- a tagged, direct-mapped BTB;
- a committed global history register (GHR).

---
 rtl/mmm_pkg.sv | 20 ++
 rtl/bpu_gshare_if.sv | 38 +++
 rtl/bpu_sat_counter_array.sv | 40 ++++
 rtl/bpu_gshare.sv | 114 +++++++++++
 tb/tb_bpu_gshare.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmm_pkg.sv
// Shared types and constants for the gshare branch prediction unit.
// Optional feature macro: BPU_SPEC_GHR_EN (speculative history register).
package mmm_pkg;

    localparam int XLEN = 32;
    localparam int HLEN = 4;

    // Tag field is sized for the smallest BTB; unused upper bits stay zero.
    typedef struct packed {
        logic            valid;
        logic [XLEN-3:0] tag;
        logic [XLEN-1:0] target;
    } btb_entry_t;

    // Weakly not-taken starting value for a counter of the given width.
    function automatic int cnt_reset(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/bpu_gshare_if.sv
// Fetch/execute side bundle of the gshare predictor.
// Optional feature macro: BPU_SPEC_GHR_EN (no effect on this bundle).
interface bpu_gshare_if #(
    parameter int HLEN = mmm_pkg::HLEN
);
    import mmm_pkg::*;

    logic            flush_i;
    logic [XLEN-1:0] pc_i;
    logic            res_valid_i;
    logic [XLEN-1:0] res_pc_i;
    logic [HLEN-1:0] res_index_i;
    logic [XLEN-1:0] res_target_i;
    logic            res_taken_i;
    logic            res_mispredict_i;
    logic [XLEN-1:0] pred_pc_o;
    logic [HLEN-1:0] pred_index_o;
    logic [XLEN-1:0] pred_target_o;
    logic            pred_taken_o;
    logic            pred_hit_o;

    modport master (
        output flush_i, pc_i, res_valid_i, res_pc_i,
        output res_index_i, res_target_i, res_taken_i,
        output res_mispredict_i,
        input  pred_pc_o, pred_index_o, pred_target_o,
        input  pred_taken_o, pred_hit_o
    );

    modport slave (
        input  flush_i, pc_i, res_valid_i, res_pc_i,
        input  res_index_i, res_target_i, res_taken_i,
        input  res_mispredict_i,
        output pred_pc_o, pred_index_o, pred_target_o,
        output pred_taken_o, pred_hit_o
    );

endinterface

// File: rtl/bpu_sat_counter_array.sv
// Pattern history table of saturating counters.
// One combinational read port, one registered update port, no bypass.
module bpu_sat_counter_array
    import mmm_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int CNT_BITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [IDX_BITS-1:0] i_rd_idx,
    output logic [CNT_BITS-1:0] o_rd_cnt,
    input  logic                i_upd_en,
    input  logic [IDX_BITS-1:0] i_upd_idx,
    input  logic                i_upd_taken
);

    localparam int DEPTH = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'(cnt_reset(CNT_BITS));

    logic [CNT_BITS-1:0] r_cnt [DEPTH];
    logic [CNT_BITS-1:0] w_cur;

    assign w_cur    = r_cnt[i_upd_idx];
    assign o_rd_cnt = r_cnt[i_rd_idx];

    // Saturating increment on taken, decrement on not-taken.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) r_cnt[i] <= CNT_RST;
        end else if (i_upd_en) begin
            if (i_upd_taken && w_cur != CNT_MAX)
                r_cnt[i_upd_idx] <= w_cur + 1'b1;
            else if (!i_upd_taken && w_cur != '0)
                r_cnt[i_upd_idx] <= w_cur - 1'b1;
        end
    end

endmodule

// File: rtl/bpu_gshare.sv
// Gshare predictor: PHT indexed by PC^history, tagged direct-mapped BTB.
// Optional feature macro: BPU_SPEC_GHR_EN adds a speculative history.
module bpu_gshare #(
    parameter int HLEN     = mmm_pkg::HLEN,
    parameter int BTB_BITS = 4,
    parameter int CNT_BITS = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    bpu_gshare_if.slave bus
);
    import mmm_pkg::*;

    localparam int BTB_DEPTH = 1 << BTB_BITS;
    localparam int TAG_SH    = BTB_BITS + 2;

    btb_entry_t          r_btb [BTB_DEPTH];
    btb_entry_t          w_entry;
    logic [HLEN-1:0]     r_ghr;
    logic [HLEN-1:0]     w_ghr_nxt;
    logic [HLEN-1:0]     w_hist;
    logic [HLEN-1:0]     w_idx;
    logic [BTB_BITS-1:0] w_slot;
    logic [BTB_BITS-1:0] w_res_slot;
    logic [XLEN-3:0]     w_tag;
    logic [XLEN-3:0]     w_res_tag;
    logic [CNT_BITS-1:0] w_cnt;
    logic                w_hit;
    logic                w_taken;
    logic                w_btb_wr;
    logic                w_unused;

    assign w_slot     = bus.pc_i[BTB_BITS+1:2];
    assign w_tag      = (XLEN-2)'(bus.pc_i >> TAG_SH);
    assign w_res_slot = bus.res_pc_i[BTB_BITS+1:2];
    assign w_res_tag  = (XLEN-2)'(bus.res_pc_i >> TAG_SH);
    assign w_entry    = r_btb[w_slot];
    assign w_idx      = bus.pc_i[HLEN+1:2] ^ w_hist;
    assign w_hit      = w_entry.valid && (w_entry.tag == w_tag);
    assign w_taken    = w_hit && w_cnt[CNT_BITS-1];
    assign w_ghr_nxt  = {r_ghr[HLEN-2:0], bus.res_taken_i};
    assign w_btb_wr   = bus.res_valid_i && bus.res_taken_i;
    assign w_unused   = ^{bus.pc_i[1:0], bus.res_pc_i[1:0],
                          bus.res_mispredict_i};

    bpu_sat_counter_array #(
        .IDX_BITS (HLEN),
        .CNT_BITS (CNT_BITS)
    ) u_pht (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .i_rd_idx    (w_idx),
        .o_rd_cnt    (w_cnt),
        .i_upd_en    (bus.res_valid_i),
        .i_upd_idx   (bus.res_index_i),
        .i_upd_taken (bus.res_taken_i)
    );

    // Taken resolutions install their target; not-taken never touch the BTB.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < BTB_DEPTH; i++) r_btb[i] <= '0;
        end else if (w_btb_wr) begin
            r_btb[w_res_slot] <= '{valid:  1'b1,
                                   tag:    w_res_tag,
                                   target: bus.res_target_i};
        end
    end

    // Committed history follows resolved outcomes only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)             r_ghr <= '0;
        else if (bus.res_valid_i) r_ghr <= w_ghr_nxt;
    end

`ifdef BPU_SPEC_GHR_EN
    logic [HLEN-1:0] r_spec_ghr;
    logic            w_recover;

    assign w_recover = (bus.res_valid_i && bus.res_mispredict_i) ||
                       bus.flush_i;
    assign w_hist    = r_spec_ghr;

    // Speculative history; recovery takes priority over a predicted shift.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_spec_ghr <= '0;
        else if (w_recover)
            r_spec_ghr <= bus.res_valid_i ? w_ghr_nxt : r_ghr;
        else if (w_hit)
            r_spec_ghr <= {r_spec_ghr[HLEN-2:0], w_taken};
    end
`else
    assign w_hist = r_ghr;
`endif

    // Registered prediction; flush only squashes the hit/taken flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.pred_pc_o     <= '0;
            bus.pred_index_o  <= '0;
            bus.pred_target_o <= '0;
            bus.pred_taken_o  <= 1'b0;
            bus.pred_hit_o    <= 1'b0;
        end else begin
            bus.pred_pc_o     <= bus.pc_i;
            bus.pred_index_o  <= w_idx;
            bus.pred_target_o <= w_entry.target;
            bus.pred_taken_o  <= w_taken && !bus.flush_i;
            bus.pred_hit_o    <= w_hit && !bus.flush_i;
        end
    end

endmodule

// File: tb/tb_bpu_gshare.sv
// Self-checking bench for bpu_gshare (HLEN=4, BTB_BITS=4, CNT_BITS=2).
// Build with BPU_SPEC_GHR_EN defined to also cover the speculative history.
module tb_bpu_gshare;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bpu_gshare_if #(.HLEN(4)) bus ();

    bpu_gshare #(
        .HLEN     (4),
        .BTB_BITS (4),
        .CNT_BITS (2)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  idx;
        logic [31:0] tgt;
        logic        hit;
        logic        tk;
    } exp_t;

    exp_t        q[$];
    int          m_cnt [16];
    logic        m_v   [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic [3:0]  m_ghr;
    logic [3:0]  m_spec;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_cnt[i] = 1;
            m_v[i]   = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
        end
        m_ghr  = '0;
        m_spec = '0;
    endtask

    task automatic idle_inputs();
        bus.flush_i          = 1'b0;
        bus.pc_i             = '0;
        bus.res_valid_i      = 1'b0;
        bus.res_pc_i         = '0;
        bus.res_index_i      = '0;
        bus.res_target_i     = '0;
        bus.res_taken_i      = 1'b0;
        bus.res_mispredict_i = 1'b0;
    endtask

    // One clock: drive, predict into the queue, update model, pop and compare.
    task automatic cycle(input logic [31:0] pc, input logic fl,
                         input logic rv, input logic [31:0] rpc,
                         input logic [3:0] ridx, input logic [31:0] rtgt,
                         input logic rt, input logic rm);
        exp_t e;
        logic [3:0] hist, idx, slot, nxt;
        logic hit, tk;
        bus.pc_i             = pc;
        bus.flush_i          = fl;
        bus.res_valid_i      = rv;
        bus.res_pc_i         = rpc;
        bus.res_index_i      = ridx;
        bus.res_target_i     = rtgt;
        bus.res_taken_i      = rt;
        bus.res_mispredict_i = rm;
`ifdef BPU_SPEC_GHR_EN
        hist = m_spec;
`else
        hist = m_ghr;
`endif
        slot = pc[5:2];
        idx  = slot ^ hist;
        hit  = m_v[slot] && (m_tag[slot] == pc[31:6]);
        tk   = hit && (m_cnt[idx] >= 2);
        e.pc  = pc;
        e.idx = idx;
        e.tgt = m_tgt[slot];
        e.hit = hit && !fl;
        e.tk  = tk && !fl;
        q.push_back(e);
        nxt = {m_ghr[2:0], rt};
        if ((rv && rm) || fl) m_spec = rv ? nxt : m_ghr;
        else if (hit)         m_spec = {m_spec[2:0], tk};
        if (rv) begin
            if (rt && m_cnt[ridx] < 3)  m_cnt[ridx]++;
            if (!rt && m_cnt[ridx] > 0) m_cnt[ridx]--;
            if (rt) begin
                m_v[rpc[5:2]]   = 1'b1;
                m_tag[rpc[5:2]] = rpc[31:6];
                m_tgt[rpc[5:2]] = rtgt;
            end
            m_ghr = nxt;
        end
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks += 4;
        if (bus.pred_pc_o !== e.pc) begin
            errors++;
            $display("FAIL sb_pc got %h exp %h", bus.pred_pc_o, e.pc);
        end
        if (bus.pred_index_o !== e.idx) begin
            errors++;
            $display("FAIL sb_idx got %h exp %h", bus.pred_index_o, e.idx);
        end
        if (bus.pred_hit_o !== e.hit) begin
            errors++;
            $display("FAIL sb_hit pc %h got %b exp %b",
                     e.pc, bus.pred_hit_o, e.hit);
        end
        if (bus.pred_taken_o !== e.tk) begin
            errors++;
            $display("FAIL sb_taken pc %h got %b exp %b",
                     e.pc, bus.pred_taken_o, e.tk);
        end
        if (e.hit) begin
            checks++;
            if (bus.pred_target_o !== e.tgt) begin
                errors++;
                $display("FAIL sb_tgt got %h exp %h",
                         bus.pred_target_o, e.tgt);
            end
        end
    endtask

    task automatic look(input logic [31:0] pc);
        cycle(pc, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic [31:0] rpc, input logic [3:0] ridx,
                           input logic [31:0] rtgt, input logic rt);
        cycle(32'h100, 1'b0, 1'b1, rpc, ridx, rtgt, rt, 1'b0);
    endtask

    task automatic test_reset();
        idle_inputs();
        m_reset();
        rst_n = 1'b0;
        #12;
        checks += 3;
        if (bus.pred_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_pc got %h exp 0", bus.pred_pc_o);
        end
        if (bus.pred_hit_o !== 1'b0 || bus.pred_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags got %b%b exp 00",
                     bus.pred_hit_o, bus.pred_taken_o);
        end
        if (bus.pred_index_o !== 4'h0) begin
            errors++;
            $display("FAIL rst_idx got %h exp 0", bus.pred_index_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_first_lookup();
        look(32'd12);
        checks += 2;
        if (bus.pred_index_o !== 4'd3) begin
            errors++;
            $display("FAIL first_idx got %0d exp 3", bus.pred_index_o);
        end
        if (bus.pred_pc_o !== 32'd12 || bus.pred_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL first_pc_hit got %h/%b exp c/0",
                     bus.pred_pc_o, bus.pred_hit_o);
        end
    endtask

    task automatic test_btb_fill();
        resolve(32'd12, 4'd3, 32'h40, 1'b1);
        look(32'd12);
`ifndef BPU_SPEC_GHR_EN
        checks += 3;
        if (bus.pred_hit_o !== 1'b1 || bus.pred_target_o !== 32'h40) begin
            errors++;
            $display("FAIL fill_hit got %b/%h exp 1/40",
                     bus.pred_hit_o, bus.pred_target_o);
        end
        if (bus.pred_index_o !== 4'd2 || bus.pred_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_idx got %0d/%b exp 2/0",
                     bus.pred_index_o, bus.pred_taken_o);
        end
        if (dut.u_pht.r_cnt[3] !== 2'd2) begin
            errors++;
            $display("FAIL fill_cnt3 got %0d exp 2", dut.u_pht.r_cnt[3]);
        end
`endif
    endtask

    task automatic test_saturate();
        resolve(32'd48, 4'd5, 32'h90, 1'b1);
        for (int i = 0; i < 4; i++) resolve(32'd52, 4'd2, 32'h80, 1'b1);
        look(32'd52);
`ifndef BPU_SPEC_GHR_EN
        checks++;
        if (bus.pred_index_o !== 4'd2 || bus.pred_taken_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_taken got %0d/%b exp 2/1",
                     bus.pred_index_o, bus.pred_taken_o);
        end
`endif
        for (int i = 0; i < 2; i++) resolve(32'd52, 4'd2, 32'h80, 1'b1);
        checks++;
        if (dut.u_pht.r_cnt[2] !== 2'd3) begin
            errors++;
            $display("FAIL sat_max got %0d exp 3", dut.u_pht.r_cnt[2]);
        end
        resolve(32'd52, 4'd2, 32'h0, 1'b0);
        checks++;
        if (dut.u_pht.r_cnt[2] !== 2'd2) begin
            errors++;
            $display("FAIL sat_dec got %0d exp 2", dut.u_pht.r_cnt[2]);
        end
        look(32'd48);
`ifndef BPU_SPEC_GHR_EN
        checks++;
        if (bus.pred_index_o !== 4'd2 || bus.pred_taken_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_weak got %0d/%b exp 2/1",
                     bus.pred_index_o, bus.pred_taken_o);
        end
`endif
    endtask

    task automatic test_same_cycle();
        cycle(32'd12, 1'b0, 1'b1, 32'd12, 4'd9, 32'h44, 1'b1, 1'b0);
        checks++;
        if (bus.pred_target_o !== 32'h40) begin
            errors++;
            $display("FAIL rw_old got %h exp 40", bus.pred_target_o);
        end
        look(32'd12);
        checks++;
        if (bus.pred_target_o !== 32'h44) begin
            errors++;
            $display("FAIL rw_new got %h exp 44", bus.pred_target_o);
        end
    endtask

    task automatic test_flush();
        cycle(32'd12, 1'b1, 1'b1, 32'h200, 4'd7, 32'h60, 1'b1, 1'b0);
        checks++;
        if (bus.pred_hit_o !== 1'b0 || bus.pred_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_sq got %b%b exp 00",
                     bus.pred_hit_o, bus.pred_taken_o);
        end
`ifdef BPU_SPEC_GHR_EN
        checks++;
        if (dut.r_spec_ghr !== m_ghr) begin
            errors++;
            $display("FAIL flush_spec got %h exp %h", dut.r_spec_ghr, m_ghr);
        end
`endif
        look(32'h200);
        checks++;
        if (bus.pred_hit_o !== 1'b1 || bus.pred_target_o !== 32'h60) begin
            errors++;
            $display("FAIL flush_upd got %b/%h exp 1/60",
                     bus.pred_hit_o, bus.pred_target_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p, r;
        for (int n = 0; n < 200; n++) begin
            p = ($urandom_range(0, 1) << 6) | ($urandom_range(0, 15) << 2) |
                $urandom_range(0, 3);
            r = ($urandom_range(0, 1) << 6) | ($urandom_range(0, 15) << 2);
            cycle(p, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 1) == 1), r,
                  4'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) == 0));
        end
    endtask

`ifdef BPU_SPEC_GHR_EN
    task automatic test_spec_recover();
        logic [3:0] want;
        for (int i = 0; i < 32; i++)
            resolve(32'd12, 4'(i), 32'h40, 1'b1);
        for (int i = 0; i < 3; i++) look(32'd12);
        want = {m_ghr[2:0], 1'b0};
        cycle(32'h100, 1'b0, 1'b1, 32'd12, 4'd0, 32'h40, 1'b0, 1'b1);
        checks++;
        if (dut.r_spec_ghr !== want) begin
            errors++;
            $display("FAIL spec_rec got %h exp %h", dut.r_spec_ghr, want);
        end
    endtask
`endif

    task automatic test_midreset();
        look(32'd12);
        bus.pc_i         = 32'h300;
        bus.res_valid_i  = 1'b1;
        bus.res_pc_i     = 32'h300;
        bus.res_target_i = 32'h70;
        bus.res_taken_i  = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pred_pc_o !== 32'h0 || bus.pred_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got %h/%b exp 0/0",
                     bus.pred_pc_o, bus.pred_hit_o);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        m_reset();
        rst_n = 1'b1;
        look(32'h300);
        look(32'd12);
        checks++;
        if (bus.pred_hit_o !== 1'b0 || bus.pred_index_o !== 4'd3) begin
            errors++;
            $display("FAIL mid_state got %b/%0d exp 0/3",
                     bus.pred_hit_o, bus.pred_index_o);
        end
    endtask

    initial begin
        test_reset();
        test_first_lookup();
        test_btb_fill();
        test_saturate();
        test_same_cycle();
        test_flush();
        test_back_to_back();
`ifdef BPU_SPEC_GHR_EN
        test_spec_recover();
`endif
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
